// File: rtl/id_ctrl_issue_pkg.sv
// Shared encodings for the ARM-subset ID/EXE path: instruction modes, data-processing
// opcodes, EXE command codes and condition codes.
package id_ctrl_issue_pkg;

  typedef enum logic [1:0] {
    MODE_ARITH  = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_NONE   = 2'b11
  } mode_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/id_ctrl_issue_cond_check.sv
// Combinational ARM condition evaluation of cond against {N,Z,C,V}.
module cond_check
  import id_ctrl_issue_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = status;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ctrl_issue.sv
// Registered decode/issue controller: decodes the ID instruction, predicates it on NZCV,
// detects RAW hazards against EXE/MEM and holds the ID/EXE control register.
module id_ctrl_issue
  import id_ctrl_issue_pkg::*;
#(
  parameter int CMD_W          = 4,
  parameter int REG_ADDR_W     = 4,
  parameter bit FORWARD_EN     = 1'b0,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [3:0]            cond,
  input  logic [1:0]            mode,
  input  logic [3:0]            opcode,
  input  logic                  s,
  input  logic                  imm,
  input  logic [REG_ADDR_W-1:0] rn,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rm,
  input  logic [3:0]            status,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  flush,
  output logic                  stall,
  output logic                  out_valid,
  output logic [CMD_W-1:0]      exe_cmd,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic                  wb_en,
  output logic                  b,
  output logic                  s_out,
  output logic [REG_ADDR_W-1:0] dest
);

  localparam int CNT_W = $clog2(LOAD_USE_STALL + 1);

  logic [CMD_W-1:0]      cmd_p0;
  logic                  mem_r_p0, mem_w_p0, wb_p0, b_p0, s_p0;
  logic                  src1_used, src2_used;
  logic [REG_ADDR_W-1:0] src2;
  logic                  cond_pass, hit_exe, hit_mem, hazard, issue;
  logic [CNT_W-1:0]      stall_cnt;

  cond_check u_cond_check (
    .cond   (cond),
    .status (status),
    .pass   (cond_pass)
  );

  // ---- p0: ID-stage decode ----
  always_comb begin
    cmd_p0    = '0;
    mem_r_p0  = 1'b0;
    mem_w_p0  = 1'b0;
    wb_p0     = 1'b0;
    b_p0      = 1'b0;
    s_p0      = 1'b0;
    src1_used = 1'b1;
    src2_used = 1'b0;
    src2      = rm;
    case (mode)
      MODE_ARITH: begin
        src2_used = !imm;
        wb_p0     = 1'b1;
        s_p0      = s;
        case (opcode)
          OP_MOV: begin cmd_p0 = CMD_W'(EXE_MOV); src1_used = 1'b0; end
          OP_MVN: begin cmd_p0 = CMD_W'(EXE_MVN); src1_used = 1'b0; end
          OP_ADD: cmd_p0 = CMD_W'(EXE_ADD);
          OP_ADC: cmd_p0 = CMD_W'(EXE_ADC);
          OP_SUB: cmd_p0 = CMD_W'(EXE_SUB);
          OP_SBC: cmd_p0 = CMD_W'(EXE_SBC);
          OP_AND: cmd_p0 = CMD_W'(EXE_AND);
          OP_ORR: cmd_p0 = CMD_W'(EXE_ORR);
          OP_EOR: cmd_p0 = CMD_W'(EXE_EOR);
          OP_CMP: begin cmd_p0 = CMD_W'(EXE_SUB); wb_p0 = 1'b0; s_p0 = 1'b1; end
          OP_TST: begin cmd_p0 = CMD_W'(EXE_AND); wb_p0 = 1'b0; s_p0 = 1'b1; end
          default: begin wb_p0 = 1'b0; s_p0 = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        cmd_p0 = CMD_W'(EXE_ADD);
        if (s) begin
          wb_p0    = 1'b1;
          mem_r_p0 = 1'b1;
        end else begin
          mem_w_p0  = 1'b1;
          src2_used = 1'b1;
          src2      = rd;
        end
      end
      MODE_BRANCH: begin
        b_p0      = 1'b1;
        src1_used = 1'b0;
      end
      default: ;
    endcase
  end

  // A failing condition still takes part in hazard detection.
  assign hit_exe = exe_wb_en && ((src1_used && rn == exe_dest) || (src2_used && src2 == exe_dest));
  assign hit_mem = mem_wb_en && ((src1_used && rn == mem_dest) || (src2_used && src2 == mem_dest));
  assign hazard  = in_valid && (FORWARD_EN ? (hit_exe && exe_mem_r_en) : (hit_exe || hit_mem));
  assign stall   = rst && !flush && (hazard || stall_cnt != '0);
  assign issue   = in_valid && !flush && !stall && cond_pass;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      stall_cnt <= '0;
    end else if (stall_cnt != '0) begin
      stall_cnt <= stall_cnt - CNT_W'(1);
    end else if (hazard) begin
      stall_cnt <= FORWARD_EN ? CNT_W'(LOAD_USE_STALL - 1) : '0;
    end
  end

  // ---- p1: ID/EXE register ----
  always_ff @(posedge clk) begin
    if (!rst || !issue) begin
      out_valid <= 1'b0;
      exe_cmd   <= '0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      wb_en     <= 1'b0;
      b         <= 1'b0;
      s_out     <= 1'b0;
      dest      <= '0;
    end else begin
      out_valid <= 1'b1;
      exe_cmd   <= cmd_p0;
      mem_r_en  <= mem_r_p0;
      mem_w_en  <= mem_w_p0;
      wb_en     <= wb_p0;
      b         <= b_p0;
      s_out     <= s_p0;
      dest      <= rd;
    end
  end

endmodule

// File: tb/tb_id_ctrl_issue.sv
// Directed bench for id_ctrl_issue: a no-forwarding instance and a load-use-forwarding
// instance share the stimulus; decode table vectors plus multi-cycle hazard sequences.
module tb_id_ctrl_issue;

  logic       clk = 1'b0;
  logic       rst, in_valid, s, imm, exe_wb_en, exe_mem_r_en, mem_wb_en, flush;
  logic [3:0] cond, opcode, rn, rd, rm, status, exe_dest, mem_dest;
  logic [1:0] mode;

  logic       stall0, out_valid0, mem_r_en0, mem_w_en0, wb_en0, b0, s_out0;
  logic [3:0] exe_cmd0, dest0;
  logic       stall1, out_valid1, mem_r_en1, mem_w_en1, wb_en1, b1, s_out1;
  logic [3:0] exe_cmd1, dest1;
  logic [13:0] word0, word1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  id_ctrl_issue #(.CMD_W(4), .REG_ADDR_W(4), .FORWARD_EN(1'b0), .LOAD_USE_STALL(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cond(cond), .mode(mode), .opcode(opcode),
    .s(s), .imm(imm), .rn(rn), .rd(rd), .rm(rm), .status(status), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .flush(flush), .stall(stall0), .out_valid(out_valid0),
    .exe_cmd(exe_cmd0), .mem_r_en(mem_r_en0), .mem_w_en(mem_w_en0), .wb_en(wb_en0),
    .b(b0), .s_out(s_out0), .dest(dest0)
  );

  id_ctrl_issue #(.CMD_W(4), .REG_ADDR_W(4), .FORWARD_EN(1'b1), .LOAD_USE_STALL(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cond(cond), .mode(mode), .opcode(opcode),
    .s(s), .imm(imm), .rn(rn), .rd(rd), .rm(rm), .status(status), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .flush(flush), .stall(stall1), .out_valid(out_valid1),
    .exe_cmd(exe_cmd1), .mem_r_en(mem_r_en1), .mem_w_en(mem_w_en1), .wb_en(wb_en1),
    .b(b1), .s_out(s_out1), .dest(dest1)
  );

  assign word0 = {out_valid0, exe_cmd0, mem_r_en0, mem_w_en0, wb_en0, b0, s_out0, dest0};
  assign word1 = {out_valid1, exe_cmd1, mem_r_en1, mem_w_en1, wb_en1, b1, s_out1, dest1};

  typedef struct {
    string      name;
    logic       inv;
    logic [3:0] cond;
    logic [1:0] mode;
    logic [3:0] opc;
    logic       s;
    logic [3:0] rd;
    logic [3:0] status;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] pack(logic v, logic [3:0] c, logic mr, logic mw,
                                       logic wb, logic bb, logic ss, logic [3:0] d);
    return {v, c, mr, mw, wb, bb, ss, d};
  endfunction

  task automatic add(string nm, logic iv, logic [3:0] cd, logic [1:0] md, logic [3:0] op,
                     logic sb, logic [3:0] r, logic [3:0] st, logic [13:0] e);
    vec_t t;
    t.name = nm; t.inv = iv; t.cond = cd; t.mode = md; t.opc = op; t.s = sb;
    t.rd = r; t.status = st; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h", nm, act, req);
    else passed++;
  endtask

  task automatic instr(logic [3:0] cd, logic [1:0] md, logic [3:0] op, logic sb, logic im,
                       logic [3:0] n, logic [3:0] d, logic [3:0] m);
    in_valid = 1'b1; cond = cd; mode = md; opcode = op; s = sb; imm = im;
    rn = n; rd = d; rm = m;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  localparam logic [13:0] BUB = 14'd0;

  initial begin
    // Decode/condition table: rn=1, rm=4, imm=0, no producer in EXE/MEM.
    add("add",     1, 4'b1110, 2'b00, 4'b0100, 0, 4'd2, 4'h0, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("add_s",   1, 4'b1110, 2'b00, 4'b0100, 1, 4'd2, 4'h0, pack(1, 4'b0010, 0, 0, 1, 0, 1, 4'd2));
    add("mov",     1, 4'b1110, 2'b00, 4'b1101, 0, 4'd2, 4'h0, pack(1, 4'b0001, 0, 0, 1, 0, 0, 4'd2));
    add("mvn",     1, 4'b1110, 2'b00, 4'b1111, 0, 4'd2, 4'h0, pack(1, 4'b1001, 0, 0, 1, 0, 0, 4'd2));
    add("adc",     1, 4'b1110, 2'b00, 4'b0101, 0, 4'd2, 4'h0, pack(1, 4'b0011, 0, 0, 1, 0, 0, 4'd2));
    add("sub",     1, 4'b1110, 2'b00, 4'b0010, 0, 4'd2, 4'h0, pack(1, 4'b0100, 0, 0, 1, 0, 0, 4'd2));
    add("sbc",     1, 4'b1110, 2'b00, 4'b0110, 0, 4'd2, 4'h0, pack(1, 4'b0101, 0, 0, 1, 0, 0, 4'd2));
    add("and",     1, 4'b1110, 2'b00, 4'b0000, 0, 4'd2, 4'h0, pack(1, 4'b0110, 0, 0, 1, 0, 0, 4'd2));
    add("orr",     1, 4'b1110, 2'b00, 4'b1100, 0, 4'd2, 4'h0, pack(1, 4'b0111, 0, 0, 1, 0, 0, 4'd2));
    add("eor",     1, 4'b1110, 2'b00, 4'b0001, 0, 4'd2, 4'h0, pack(1, 4'b1000, 0, 0, 1, 0, 0, 4'd2));
    add("cmp",     1, 4'b1110, 2'b00, 4'b1010, 1, 4'd2, 4'h0, pack(1, 4'b0100, 0, 0, 0, 0, 1, 4'd2));
    add("tst",     1, 4'b1110, 2'b00, 4'b1000, 1, 4'd2, 4'h0, pack(1, 4'b0110, 0, 0, 0, 0, 1, 4'd2));
    add("undef",   1, 4'b1110, 2'b00, 4'b0011, 1, 4'd0, 4'h0, pack(1, 4'b0000, 0, 0, 0, 0, 0, 4'd0));
    add("ldr",     1, 4'b1110, 2'b01, 4'b0100, 1, 4'd2, 4'h0, pack(1, 4'b0010, 1, 0, 1, 0, 0, 4'd2));
    add("str",     1, 4'b1110, 2'b01, 4'b0100, 0, 4'd2, 4'h0, pack(1, 4'b0010, 0, 1, 0, 0, 0, 4'd2));
    add("branch",  1, 4'b1110, 2'b10, 4'b0000, 0, 4'd2, 4'h0, pack(1, 4'b0000, 0, 0, 0, 1, 0, 4'd2));
    add("mode11",  1, 4'b1110, 2'b11, 4'b0100, 1, 4'd0, 4'h0, pack(1, 4'b0000, 0, 0, 0, 0, 0, 4'd0));
    add("no_inv",  0, 4'b1110, 2'b00, 4'b0100, 0, 4'd2, 4'h0, BUB);
    add("eq_fail", 1, 4'b0000, 2'b00, 4'b0100, 0, 4'd2, 4'h0, BUB);
    add("eq_pass", 1, 4'b0000, 2'b00, 4'b0100, 0, 4'd2, 4'h4, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("ne_fail", 1, 4'b0001, 2'b00, 4'b0100, 0, 4'd2, 4'h4, BUB);
    add("cs_pass", 1, 4'b0010, 2'b00, 4'b0100, 0, 4'd2, 4'h2, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("cc_fail", 1, 4'b0011, 2'b00, 4'b0100, 0, 4'd2, 4'h2, BUB);
    add("mi_pass", 1, 4'b0100, 2'b00, 4'b0100, 0, 4'd2, 4'h8, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("pl_fail", 1, 4'b0101, 2'b00, 4'b0100, 0, 4'd2, 4'h8, BUB);
    add("vs_pass", 1, 4'b0110, 2'b00, 4'b0100, 0, 4'd2, 4'h1, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("vc_fail", 1, 4'b0111, 2'b00, 4'b0100, 0, 4'd2, 4'h1, BUB);
    add("hi_pass", 1, 4'b1000, 2'b00, 4'b0100, 0, 4'd2, 4'h2, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("hi_fail", 1, 4'b1000, 2'b00, 4'b0100, 0, 4'd2, 4'h6, BUB);
    add("ls_fail", 1, 4'b1001, 2'b00, 4'b0100, 0, 4'd2, 4'h2, BUB);
    add("ls_pass", 1, 4'b1001, 2'b00, 4'b0100, 0, 4'd2, 4'h6, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("ge_pass", 1, 4'b1010, 2'b00, 4'b0100, 0, 4'd2, 4'h9, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("ge_fail", 1, 4'b1010, 2'b00, 4'b0100, 0, 4'd2, 4'h8, BUB);
    add("lt_pass", 1, 4'b1011, 2'b00, 4'b0100, 0, 4'd2, 4'h8, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("gt_pass", 1, 4'b1100, 2'b00, 4'b0100, 0, 4'd2, 4'h0, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("gt_fail", 1, 4'b1100, 2'b00, 4'b0100, 0, 4'd2, 4'h4, BUB);
    add("le_pass", 1, 4'b1101, 2'b00, 4'b0100, 0, 4'd2, 4'h4, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));
    add("nv_fail", 1, 4'b1111, 2'b00, 4'b0100, 0, 4'd2, 4'hF, BUB);

    // Reset held two cycles with a live hazard present.
    rst = 1'b0; flush = 1'b0; status = 4'h0;
    instr(4'b1110, 2'b00, 4'b0100, 1'b0, 1'b0, 4'd1, 4'd2, 4'd4);
    exe_dest = 4'd1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; mem_dest = 4'd0; mem_wb_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_stall0", stall0, 0);
      chk("rst_stall1", stall1, 0);
      edge1();
      chk("rst_word0", word0, BUB);
      chk("rst_word1", word1, BUB);
    end
    rst = 1'b1; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    #1 chk("rel_stall0", stall0, 0);
    edge1();
    chk("rel_word0", word0, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));

    foreach (vecs[i]) begin
      instr(vecs[i].cond, vecs[i].mode, vecs[i].opc, vecs[i].s, 1'b0, 4'd1, vecs[i].rd, 4'd4);
      in_valid = vecs[i].inv;
      status = vecs[i].status;
      #1 chk({vecs[i].name, "_stall"}, stall0, 0);
      edge1();
      chk(vecs[i].name, word0, vecs[i].exp);
    end
    status = 4'h0;

    // No forwarding: RAW on rn against EXE.
    instr(4'b1110, 2'b00, 4'b0100, 1'b0, 1'b0, 4'd3, 4'd2, 4'd4);
    exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1 chk("raw_exe_stall", stall0, 1);
    chk("raw_exe_fwd_nostall", stall1, 0);
    edge1();
    chk("raw_exe_bubble", out_valid0, 0);
    exe_wb_en = 1'b0;
    #1 chk("raw_exe_clear", stall0, 0);
    edge1();
    chk("raw_exe_issue", word0, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));

    // Forwarding, load-use on rm with two bubbles.
    instr(4'b1110, 2'b00, 4'b0010, 1'b0, 1'b0, 4'd1, 4'd6, 4'd5);
    exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1 chk("lu_stall_c0", stall1, 1);
    edge1();
    chk("lu_bubble_c0", out_valid1, 0);
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    #1 chk("lu_stall_c1", stall1, 1);
    edge1();
    chk("lu_bubble_c1", out_valid1, 0);
    #1 chk("lu_stall_c2", stall1, 0);
    edge1();
    chk("lu_issue", word1, pack(1, 4'b0100, 0, 0, 1, 0, 0, 4'd6));
    mem_dest = 4'd5; mem_wb_en = 1'b1;
    #1 chk("fwd_mem_nostall", stall1, 0);
    chk("nofwd_mem_stall", stall0, 1);
    edge1();
    mem_wb_en = 1'b0;

    // Flush beats a load-use hazard and leaves no residual stall.
    exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; flush = 1'b1;
    #1 chk("flush_stall1", stall1, 0);
    chk("flush_stall0", stall0, 0);
    edge1();
    chk("flush_word1", word1, BUB);
    chk("flush_word0", word0, BUB);
    flush = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    instr(4'b1110, 2'b00, 4'b0100, 1'b0, 1'b0, 4'd1, 4'd3, 4'd4);
    #1 chk("post_flush_stall", stall1, 0);
    edge1();
    chk("post_flush_issue", word1, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd3));

    // STR reads rd as a source; RAW against MEM.
    instr(4'b1110, 2'b01, 4'b0100, 1'b0, 1'b0, 4'd1, 4'd7, 4'd4);
    mem_dest = 4'd7; mem_wb_en = 1'b1;
    #1 chk("str_stall", stall0, 1);
    edge1();
    chk("str_bubble", out_valid0, 0);
    mem_wb_en = 1'b0;
    #1 chk("str_clear", stall0, 0);
    edge1();
    chk("str_issue", word0, pack(1, 4'b0010, 0, 1, 0, 0, 0, 4'd7));

    // Reset in the middle of a load-use stall.
    instr(4'b1110, 2'b00, 4'b0100, 1'b0, 1'b0, 4'd5, 4'd2, 4'd4);
    exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1 chk("mid_stall_set", stall1, 1);
    edge1();
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; rst = 1'b0;
    #1 chk("mid_rst_forced", stall1, 0);
    edge1();
    chk("mid_rst_word", word1, BUB);
    rst = 1'b1;
    #1 chk("mid_rst_cleared", stall1, 0);
    edge1();
    chk("mid_rst_issue", word1, pack(1, 4'b0010, 0, 0, 1, 0, 0, 4'd2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
